// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and helpers for the digit-serial adder.
//   - state_t   : controller state encoding (2 bits)
//   - cnt_width : width of the digit counter for a given WIDTH/DIGIT split
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit over $clog2(N) so that N == 1 still yields a 1-bit
    // counter and the terminal compare never needs a zero-width vector.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = (digit > 0) ? (width / digit) : 1;
        if (n < 1) begin
            n = 1;
        end
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder
//   Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
//   Ports:
//     x, y   : DIGIT-bit addends
//     ci     : carry into bit 0
//     s      : DIGIT-bit sum
//     co     : carry out of the top bit
//     c_msb  : carry into the top bit (used for signed overflow)
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder computing a + b + cin, DIGIT bits per clock, with a
//   registered carry between digits and a start/busy/done handshake.
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     start     : request, accepted in IDLE or DONE
//     a, b, cin : operands, sampled only on the accepting edge
//     busy      : high while digits are being processed
//     done      : one-cycle pulse when sum/cout/overflow are fresh
//     sum       : WIDTH-bit result (mod 2^WIDTH), held until next completion
//     cout      : unsigned carry-out, held with sum
//     overflow  : signed overflow, held with sum
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | one digit added per edge, LSB digit first
//   DONE  | results committed, done high; start here chains the next add
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] d_s;
    logic             d_co;
    logic             d_cmsb;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x     (a_sh[DIGIT-1:0]),
        .y     (b_sh[DIGIT-1:0]),
        .ci    (carry),
        .s     (d_s),
        .co    (d_co),
        .c_msb (d_cmsb)
    );

    // New digits enter at the top, so after N steps the first (least
    // significant) digit has reached bit 0.
    if (N == 1) begin : g_one_digit
        assign sum_sh_nxt = d_s;
    end else begin : g_multi_digit
        assign sum_sh_nxt = {d_s, sum_sh[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = (cnt == LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            // Registered from next state so busy/done never see start combinationally.
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (step) begin
                a_sh   <= a_sh >> DIGIT;
                b_sh   <= b_sh >> DIGIT;
                carry  <= d_co;
                cnt    <= cnt + CW'(1);
                sum_sh <= sum_sh_nxt;
                if (last) begin
                    sum      <= sum_sh_nxt;
                    cout     <= d_co;
                    overflow <= d_co ^ d_cmsb;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=8, DIGIT=1
    logic       st8 = 0, ci8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       busy8, done8, co8, ov8;
    logic [7:0] sum8;

    // WIDTH=16, DIGIT=4
    logic        st16 = 0, ci16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy16, done16, co16, ov16;
    logic [15:0] sum16;

    // WIDTH=4, DIGIT=2
    logic       st4 = 0, ci4 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic       busy4, done4, co4, ov4;
    logic [3:0] sum4;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_a8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(co8), .overflow(ov8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_a16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .cin(ci16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(co16), .overflow(ov16)
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_a4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(ci4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(co4), .overflow(ov4)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0]  prev8  = 8'h00;
    logic [15:0] prev16 = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one add on the 8/1 instance and wait for done; ends sampled in the done cycle.
    task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic [7:0] es, input logic ec, input logic eo);
        int k;
        int nb;
        @(negedge clk);
        a8 = ia; b8 = ib; ci8 = ic; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        k = 0;
        nb = 0;
        while (!done8 && k < 40) begin
            if (busy8) nb++;
            check({tag, " hold"}, {24'd0, sum8}, {24'd0, prev8});
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k + 1, 9);
        check({tag, " busy_cycles"}, nb, 8);
        check({tag, " sum"}, {24'd0, sum8}, {24'd0, es});
        check({tag, " cout"}, {31'd0, co8}, {31'd0, ec});
        check({tag, " ovf"}, {31'd0, ov8}, {31'd0, eo});
        prev8 = es;
    endtask

    // 16/4 instance; b2b launches start in the current (done) cycle.
    task automatic op16(input string tag, input bit b2b, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic [15:0] es, input logic ec, input logic eo);
        int k;
        if (!b2b) @(negedge clk);
        a16 = ia; b16 = ib; ci16 = ic; st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        k = 0;
        while (!done16 && k < 40) begin
            check({tag, " hold"}, {16'd0, sum16}, {16'd0, prev16});
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k + 1, 5);
        check({tag, " sum"}, {16'd0, sum16}, {16'd0, es});
        check({tag, " cout"}, {31'd0, co16}, {31'd0, ec});
        check({tag, " ovf"}, {31'd0, ov16}, {31'd0, eo});
        prev16 = es;
    endtask

    initial begin
        int pulses;
        int busy_seen;
        int k;
        logic [7:0] got_sum;
        logic got_co, got_ov;
        logic [3:0] prev4;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy8", {31'd0, busy8}, 0);
        check("rst done8", {31'd0, done8}, 0);
        check("rst sum8", {24'd0, sum8}, 0);
        check("rst cout8", {31'd0, co8}, 0);
        check("rst ovf8", {31'd0, ov8}, 0);
        check("rst sum16", {16'd0, sum16}, 0);
        check("rst busy4", {31'd0, busy4}, 0);
        rst_n = 1'b1;

        // Basic 8-bit adds
        op8("0f+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        check("single pulse", {31'd0, done8}, 0);
        check("sum held", {24'd0, sum8}, 32'h10);
        op8("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Start and operand changes while busy are ignored
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        pulses = 0;
        got_sum = 8'hxx; got_co = 1'bx; got_ov = 1'bx;
        for (int j = 0; j < 15; j++) begin
            if (j == 2) begin
                st8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1;
            end
            if (j == 3) st8 = 1'b0;
            if (done8) begin
                pulses++;
                got_sum = sum8; got_co = co8; got_ov = ov8;
            end
            @(negedge clk);
        end
        check("busy start pulses", pulses, 1);
        check("busy start sum", {24'd0, got_sum}, 32'h46);
        check("busy start cout", {31'd0, got_co}, 0);
        check("busy start ovf", {31'd0, got_ov}, 0);
        prev8 = 8'h46;

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-abort busy", {31'd0, busy8}, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy8}, 0);
        check("abort done", {31'd0, done8}, 0);
        check("abort sum", {24'd0, sum8}, 0);
        check("abort cout", {31'd0, co8}, 0);
        check("abort ovf", {31'd0, ov8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        busy_seen = 0;
        for (int j = 0; j < 12; j++) begin
            if (done8) pulses++;
            if (busy8) busy_seen++;
            @(negedge clk);
        end
        check("post-abort done", pulses, 0);
        check("post-abort busy", busy_seen, 0);
        prev8 = 8'h00;
        op8("after abort", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        // 16-bit, 4-bit digits, back-to-back
        op16("ffff+1+1", 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);
        op16("b2b 1234+1111", 1'b1, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        op16("7000+1000", 1'b0, 16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1);

        // 4-bit, 2-bit digits: all operand/carry combinations
        prev4 = 4'h0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    int r;
                    int sr;
                    logic [3:0] es;
                    logic ec;
                    logic eo;
                    r  = ia + ib + ic;
                    es = r[3:0];
                    ec = r[4];
                    sr = ((ia >= 8) ? ia - 16 : ia) + ((ib >= 8) ? ib - 16 : ib) + ic;
                    eo = (sr > 7) || (sr < -8);
                    @(negedge clk);
                    a4 = ia[3:0]; b4 = ib[3:0]; ci4 = ic[0]; st4 = 1'b1;
                    @(negedge clk);
                    st4 = 1'b0;
                    k = 0;
                    while (!done4 && k < 20) begin
                        check("x4 hold", {28'd0, sum4}, {28'd0, prev4});
                        @(negedge clk);
                        k++;
                    end
                    check("x4 latency", k + 1, 3);
                    check("x4 sum", {28'd0, sum4}, {28'd0, es});
                    check("x4 cout", {31'd0, co4}, {31'd0, ec});
                    check("x4 ovf", {31'd0, ov4}, {31'd0, eo});
                    prev4 = es;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
